hs_rsp_sched: RTL
=================

# hs_rsp_sched

Completion scheduler for the SATA host-side response interface. Collects per-slot command completions from up to NREQ engines (PIO, DMA, NCQ set-device-bits, error handler) and queues them in a small FIFO. Presents them one at a time to the host response channel with a RspReq/RspAck handshake. Sits between the transport-layer engines and the response-register interface in sata_hs.

## Interface
- NREQ, 4: number of completion requesters, 2..8.
- FIFO_DEPTH, 8: queued completions, power of two, 2..32.
- sys_clk  in  1  single clock for the whole block.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req_vld  in  NREQ  requester i holds a completion.
- req_id  in  5*NREQ  command slot tag; bits [5i+4:5i] belong to requester i.
- req_sts  in  NREQ  completion status; 1 = error.
- req_rdy  out  NREQ  one-hot grant; completion i is accepted when req_vld[i] & req_rdy[i].
- RspReq  out  1  response pending towards the host.
- RspId  out  5  slot tag of the presented response.
- RspSts  out  1  status of the presented response.
- RspAck  in  1  host has consumed the presented response.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  queued entries, excluding the one being presented.
- busy  out  1  RspReq | (fifo_cnt != 0).

## Operation
- Reset values: req_rdy=0, RspReq=0, RspId=0, RspSts=0, fifo_cnt=0, busy=0, round-robin pointer=0, state=IDLE.
- Arbitration is combinational round-robin over eligible requesters.
  - Requester i is eligible when req_vld[i] is high, the FIFO is not full, and (with DUP_CHK) its tag is not pending.
  - Search starts at the pointer. After a grant to i, the pointer becomes (i+1) mod NREQ.
  - The pointer does not move when there is no grant.
- One push per cycle at most. A full FIFO blocks pushes even in a cycle where a pop occurs.
- Output FSM has three states:
  - IDLE: if the FIFO is not empty, pop the head into the RspId/RspSts registers, set RspReq=1, and go to REQ.
  - REQ: RspReq, RspId and RspSts hold stable. On RspAck=1, clear RspReq and go to GAP.
  - GAP: RspReq stays low for exactly one cycle, then go to IDLE.
- RspAck seen in IDLE or GAP is ignored.
- Reset mid-operation: all state clears asynchronously. RspReq drops at once and queued completions are discarded.

## Timing
- Push at edge N means RspReq rises at edge N+2 when the FIFO was empty and the FSM was in IDLE.
- RspAck sampled at edge M means RspReq falls at M+1. The next RspReq can rise no earlier than M+3.
- The host holds RspAck for one cycle. If RspAck is held longer, only the first sampled cycle counts.
- Sustained throughput: one completion per 3 cycles when the host acks immediately.
- All outputs are registered except req_rdy.
- fifo_cnt updates on the edge after a push or pop. A simultaneous push and pop leave it unchanged.

## Configuration
- HS_RSP_DUP_CHK_EN defined:
  - A 32-bit pending bitmap is set on push and cleared on RspAck for RspId.
  - A requester whose tag is already pending is ineligible and waits; it is not dropped.
  - Two requesters in the same cycle with the same non-pending tag: only the round-robin winner is granted.
- HS_RSP_DUP_CHK_EN undefined:
  - No bitmap is built. Duplicate tags are queued and presented twice.

## Structure
- Package hs_rsp_pkg holds:
  - RSP_ID_W = 5.
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, GAP=2'd2.
  - Packed completion entry: {sts, id}, 6 bits.
- Sub-module hs_rsp_fifo: synchronous FIFO, FIFO_DEPTH x 6 bits, with push/pop/full/empty/count and wrap-around pointers.
- Arbiter, FSM and bitmap live in hs_rsp_sched.

## Test plan
- Single completion: req_vld[0]=1, id=5'd7, sts=0 at edge 10 -> req_rdy[0]=1 in that cycle; RspReq=1, RspId=7, RspSts=0 at edge 12; after RspAck at edge 15, RspReq=0 at edge 16.
- Fairness: all four requesters hold ids 1,2,3,4 continuously with pointer=0 -> grant order 0,1,2,3,0; five entries queued over five cycles.
- Full: 8 completions queued with the host not acking -> fifo_cnt=8 and req_rdy=0. One RspAck pops an entry -> exactly one more push accepted.
- Handshake hold: RspAck low for 20 cycles -> RspId and RspSts unchanged and RspReq high throughout. A 3-cycle RspAck pulse -> one entry consumed only.
- Duplicate (HS_RSP_DUP_CHK_EN): tag 9 in flight and req_id=9 on requester 2 -> req_rdy[2]=0 until the cycle after the ack of tag 9, then granted.
- Reset: sys_rst_n low while in REQ with 3 entries queued -> RspReq=0 and fifo_cnt=0 immediately; after release, no response until a new push.

Source files
------------

// File: rtl/hs_rsp_pkg.sv
// Shared types and constants for the host-side completion scheduler.
//   RSP_ID_W    : width of a command slot tag.
//   RSP_ENT_W   : width of one queued completion ({sts, id}).
//   rsp_state_e : output handshake FSM encoding.
//   rsp_entry_t : packed completion entry.
package hs_rsp_pkg;

    localparam int RSP_ID_W  = 5;
    localparam int RSP_ENT_W = RSP_ID_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic                sts;
        logic [RSP_ID_W-1:0] id;
    } rsp_entry_t;

    function automatic rsp_entry_t make_entry(input logic sts, input logic [RSP_ID_W-1:0] id);
        rsp_entry_t e;
        e.sts = sts;
        e.id  = id;
        return e;
    endfunction

endpackage

// File: rtl/hs_rsp_fifo.sv
// Synchronous FIFO holding queued completions.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write one entry (ignored when full)
//   pop_i/rdata_o : read head (rdata_o shows the head combinationally; pop ignored when empty)
//   full_o/empty_o/count_o : occupancy status
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module hs_rsp_fifo
    import hs_rsp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [RSP_ENT_W-1:0]   wdata_i,
    input  logic                   pop_i,
    output logic [RSP_ENT_W-1:0]   rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [RSP_ENT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hs_rsp_sched.sv
// Completion scheduler: round-robin collects completions from NREQ engines into
// a FIFO and presents them one at a time on the RspReq/RspAck channel.
//   sys_clk, sys_rst_n         : clock, asynchronous active-low reset
//   req_vld/req_id/req_sts     : per-requester completion (id bits [5i+4:5i])
//   req_rdy                    : one-hot combinational grant
//   RspReq/RspId/RspSts/RspAck : host response handshake (registered outputs)
//   fifo_cnt, busy             : queued entries (excluding presented one), activity
// Optional feature macro HS_RSP_DUP_CHK_EN: pending-tag bitmap that holds off a
// requester whose tag is still queued or presented.
//
// Handshakes: a completion transfers on a clock edge where req_vld[i] & req_rdy[i];
// req_vld must not depend on req_rdy. A response is offered while RspReq is high
// with RspId/RspSts stable; the first edge sampling RspAck high consumes it, after
// which RspReq stays low for one full cycle before the next response.
module hs_rsp_sched
    import hs_rsp_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [NREQ-1:0]             req_vld,
    input  logic [5*NREQ-1:0]           req_id,
    input  logic [NREQ-1:0]             req_sts,
    output logic [NREQ-1:0]             req_rdy,
    output logic                        RspReq,
    output logic [4:0]                  RspId,
    output logic                        RspSts,
    input  logic                        RspAck,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        busy
);

    localparam int PW = $clog2(NREQ);

    rsp_state_e           state_q, state_d;
    logic                 rsp_req_q, rsp_req_d;
    rsp_entry_t           rsp_ent_q, rsp_ent_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [NREQ-1:0]      elig;
    logic                 push, pop, ack_take;
    rsp_entry_t           push_ent;
    logic [RSP_ENT_W-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic [PW:0]          arb_sum;
    logic [PW-1:0]        arb_idx;

`ifdef HS_RSP_DUP_CHK_EN
    logic [(1<<RSP_ID_W)-1:0] pend_q, pend_d;
`endif

    // Eligibility: a full FIFO blocks every push, even if a pop happens this cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_vld[i] & ~fifo_full;
`ifdef HS_RSP_DUP_CHK_EN
            elig[i] = elig[i] & ~pend_q[req_id[RSP_ID_W*i +: RSP_ID_W]];
`endif
        end
    end

    // Round-robin: scan from rr_q upward with wrap; first eligible wins.
    always_comb begin
        req_rdy  = '0;
        rr_d     = rr_q;
        push     = 1'b0;
        push_ent = '0;
        arb_sum  = '0;
        arb_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_sum = {1'b0, rr_q} + (PW+1)'(k);
            if (arb_sum >= (PW+1)'(NREQ)) arb_sum = arb_sum - (PW+1)'(NREQ);
            arb_idx = arb_sum[PW-1:0];
            if (!push && elig[arb_idx]) begin
                push             = 1'b1;
                req_rdy[arb_idx] = 1'b1;
                push_ent         = make_entry(req_sts[arb_idx],
                                              req_id[RSP_ID_W*arb_idx +: RSP_ID_W]);
                rr_d             = (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    hs_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (push),
        .wdata_i (push_ent),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Output FSM. RspAck outside REQ has no effect, so a long ack consumes one entry.
    always_comb begin
        state_d   = state_q;
        rsp_req_d = rsp_req_q;
        rsp_ent_d = rsp_ent_q;
        pop       = 1'b0;
        ack_take  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    rsp_ent_d = fifo_rdata;
                    rsp_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (RspAck) begin
                    ack_take  = 1'b1;
                    rsp_req_d = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef HS_RSP_DUP_CHK_EN
    // Tag is pending from its push until the host acks it.
    always_comb begin
        pend_d = pend_q;
        if (ack_take) pend_d[rsp_ent_q.id] = 1'b0;
        if (push)     pend_d[push_ent.id]  = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pend_q <= '0;
        else            pend_q <= pend_d;
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            rsp_req_q <= 1'b0;
            rsp_ent_q <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            rsp_req_q <= rsp_req_d;
            rsp_ent_q <= rsp_ent_d;
            rr_q      <= rr_d;
        end
    end

    assign RspReq = rsp_req_q;
    assign RspId  = rsp_ent_q.id;
    assign RspSts = rsp_ent_q.sts;
    assign busy   = rsp_req_q | (fifo_cnt != '0);

endmodule
